ofm_writeback: RTL and testbench

- Output-side collector for Sub_top_CONV.
- Captures the 16 per-PE OFM bytes on each all-lanes-valid beat and buffers them in a small beat FIFO.
- Packs the bytes into four 32-bit words and writes them through a single-port OFM BRAM write interface: we/addr/data, one word per cycle.
- Mirrors the IFM/weight load path, in the opposite direction: PE array → memory.

---
 rtl/ofm_wb_pkg.sv | 27 ++
 rtl/ofm_beat_fifo.sv | 47 ++++
 rtl/ofm_writeback.sv | 163 ++++++++++++++++
 tb/tb_ofm_writeback.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_wb_pkg.sv
// Shared types and constants for the OFM writeback path (PE array -> OFM BRAM).
package ofm_wb_pkg;

    localparam int unsigned LANES          = 16;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORDS_PER_BEAT = 4;
    localparam int unsigned BEAT_W         = LANES * 8;

    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    // Word wsel of a beat: lane 4*wsel lands in the top byte.
    function automatic logic [31:0] pack_word(input beat_t beat, input logic [1:0] wsel);
        logic [31:0] word;
        word = '0;
        for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
            word[8*(BYTES_PER_WORD-1-b) +: 8] = beat[8*(BYTES_PER_WORD*32'(wsel) + b) +: 8];
        end
        return word;
    endfunction

endpackage

// File: rtl/ofm_beat_fifo.sv
// Synchronous beat FIFO; pointers carry one extra wrap bit to separate full from empty.
module ofm_beat_fifo
    import ofm_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_push,
    input  logic  i_pop,
    input  beat_t i_din,
    output beat_t o_dout,
    output logic  o_full,
    output logic  o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    beat_t           r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/ofm_writeback.sv
// Collects all-lanes-valid OFM beats and writes them to the OFM BRAM as four 32-bit words.
// Optional macro OFM_WB_RELU_EN: clamp negative (bit7 set) lane bytes to zero at FIFO output.
module ofm_writeback
    import ofm_wb_pkg::*;
#(
    parameter int unsigned NUM_PIXELS = 3136,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_BASE  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LANES-1:0] i_valid,
    input  beat_t            i_ofm_in,
    output logic             o_ofm_ready,
    output logic             o_ofm_we,
    output logic [31:0]      o_ofm_addr,
    output logic [31:0]      o_ofm_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic             o_lane_err
);

    localparam int unsigned    BCW         = $clog2(NUM_PIXELS + 1);
    localparam logic [BCW-1:0] BEAT_MAX    = BCW'(NUM_PIXELS);
    localparam logic [31:0]    TOTAL_WORDS = 32'(WORDS_PER_BEAT * NUM_PIXELS);
    localparam logic [31:0]    BASE        = 32'(ADDR_BASE);

    wb_state_t       r_state,    w_state_nxt;
    logic [BCW-1:0]  r_beat_cnt, w_beat_cnt_nxt;
    logic [31:0]     r_word_cnt, w_word_cnt_nxt;
    logic [1:0]      r_wsel,     w_wsel_nxt;
    logic            r_we,       w_we_nxt;
    logic [31:0]     r_addr,     w_addr_nxt;
    logic [31:0]     r_data,     w_data_nxt;
    logic            r_busy,     r_done;
    logic            r_ovf,      w_ovf_nxt;
    logic            r_lerr,     w_lerr_nxt;

    logic            w_push, w_pop, w_full, w_empty;
    logic            w_all_valid, w_part_valid, w_drain;
    beat_t           w_head, w_head_clamped;
    logic [31:0]     w_word;

    ofm_beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (i_ofm_in),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Lane clamp sits between FIFO head and the packer, so it costs no cycle.
    always_comb begin
        w_head_clamped = w_head;
`ifdef OFM_WB_RELU_EN
        for (int unsigned k = 0; k < LANES; k++) begin
            if (w_head[8*k+7]) w_head_clamped[8*k +: 8] = 8'h00;
        end
`endif
        w_word = pack_word(w_head_clamped, r_wsel);
    end

    assign w_all_valid  = (i_valid == '1);
    assign w_part_valid = (i_valid != '0) && !w_all_valid;
    assign w_drain      = (r_state == RUN) && !w_empty && (r_word_cnt < TOTAL_WORDS);

    // Next-state, capture and drain decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_word_cnt_nxt = r_word_cnt;
        w_wsel_nxt     = r_wsel;
        w_we_nxt       = 1'b0;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_ovf_nxt      = r_ovf;
        w_lerr_nxt     = r_lerr;
        w_push         = 1'b0;
        w_pop          = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_state_nxt    = RUN;
                    w_beat_cnt_nxt = '0;
                    w_word_cnt_nxt = '0;
                    w_wsel_nxt     = '0;
                    w_ovf_nxt      = 1'b0;
                    w_lerr_nxt     = 1'b0;
                end
            end
            RUN: begin
                if (w_all_valid) begin
                    if (r_beat_cnt < BEAT_MAX) begin
                        if (!w_full) begin
                            w_push         = 1'b1;
                            w_beat_cnt_nxt = r_beat_cnt + BCW'(1);
                        end else begin
                            w_ovf_nxt = 1'b1;
                        end
                    end
                end else if (w_part_valid) begin
                    w_lerr_nxt = 1'b1;
                end

                if (w_drain) begin
                    w_we_nxt       = 1'b1;
                    w_addr_nxt     = BASE + r_word_cnt;
                    w_data_nxt     = w_word;
                    w_word_cnt_nxt = r_word_cnt + 32'd1;
                    w_wsel_nxt     = r_wsel + 2'd1;
                    w_pop          = (r_wsel == 2'(WORDS_PER_BEAT - 1));
                end

                if (r_word_cnt == TOTAL_WORDS) w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_word_cnt <= '0;
            r_wsel     <= '0;
            r_we       <= 1'b0;
            r_addr     <= BASE;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_lerr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_wsel     <= w_wsel_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_busy     <= (w_state_nxt == RUN);
            r_done     <= (w_state_nxt == DONE);
            r_ovf      <= w_ovf_nxt;
            r_lerr     <= w_lerr_nxt;
        end
    end

    assign o_ofm_ready = !w_full;
    assign o_ofm_we    = r_we;
    assign o_ofm_addr  = r_addr;
    assign o_ofm_data  = r_data;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_overflow  = r_ovf;
    assign o_lane_err  = r_lerr;

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback with a write scoreboard (NUM_PIXELS=6, ADDR_BASE=0x100).
module tb_ofm_writeback;

    localparam int unsigned NPIX  = 6;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h100;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [15:0]   valid;
    logic [127:0]  ofm_in;
    logic          ofm_ready, ofm_we, busy, done, overflow, lane_err;
    logic [31:0]   ofm_addr, ofm_data;

    wr_t           exp_q[$];
    logic [31:0]   exp_addr;
    int            n_checks;
    int            n_errors;

    ofm_writeback #(.NUM_PIXELS(NPIX), .FIFO_DEPTH(DEPTH), .ADDR_BASE(BASE)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_valid     (valid),
        .i_ofm_in    (ofm_in),
        .o_ofm_ready (ofm_ready),
        .o_ofm_we    (ofm_we),
        .o_ofm_addr  (ofm_addr),
        .o_ofm_data  (ofm_data),
        .o_busy      (busy),
        .o_done      (done),
        .o_overflow  (overflow),
        .o_lane_err  (lane_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference word: bytes taken from lane 4w upward, first byte ends up most significant.
    function automatic logic [31:0] exp_word(input logic [127:0] b, input int w);
        logic [31:0] r;
        logic [7:0]  byt;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            byt = b[8*(4*w+j) +: 8];
`ifdef OFM_WB_RELU_EN
            if (byt > 8'h7F) byt = 8'h00;
`endif
            r = {r[23:0], byt};
        end
        return r;
    endfunction

    function automatic logic [127:0] make_beat(input logic [7:0] seed);
        logic [127:0] b;
        for (int k = 0; k < 16; k++) b[8*k +: 8] = seed + 8'(k);
        return b;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [127:0] b, input bit acc);
        valid  = 16'hFFFF;
        ofm_in = b;
        if (acc) begin
            for (int w = 0; w < 4; w++) begin
                exp_q.push_back('{addr: exp_addr, data: exp_word(b, w)});
                exp_addr = exp_addr + 32'd1;
            end
        end
        tick();
        valid = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = BASE;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: every write must match the oldest expected word.
    always @(negedge clk) begin
        wr_t e;
        if (ofm_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 32'(ofm_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", ofm_addr, e.addr);
                check("wr_data", ofm_data, e.data);
            end
        end
    end

    initial begin
        logic [127:0] b;
        n_checks = 0;
        n_errors = 0;
        exp_addr = BASE;
        rst_n    = 1'b1;
        start    = 1'b0;
        valid    = '0;
        ofm_in   = '0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_we",    32'(ofm_we),    32'd0);
        check("rst_addr",  ofm_addr,       BASE);
        check("rst_data",  ofm_data,       32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        check("rst_lerr",  32'(lane_err),  32'd0);
        check("rst_ready", 32'(ofm_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // valid in IDLE is ignored
        drive_beat(make_beat(8'h40), 1'b0);
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Byte packing and first-write latency
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        drive_beat(make_beat(8'h00), 1'b1);
        check("lat_we0", 32'(ofm_we), 32'd0);
        tick();
        check("lat_we1",   32'(ofm_we), 32'd1);
        check("pack_w0",   ofm_data,    32'h00010203);
        check("pack_a0",   ofm_addr,    BASE);
        tick();
        check("pack_w1",   ofm_data,    32'h04050607);
        tick();
        check("pack_w2",   ofm_data,    32'h08090A0B);
        tick();
        check("pack_w3",   ofm_data,    32'h0C0D0E0F);
        wait_drain("drain_pack");

        // Partial valid: no write, sticky lane_err
        valid = 16'h00FF;
        ofm_in = make_beat(8'h55);
        tick();
        valid = '0;
        tick();
        check("part_lerr", 32'(lane_err), 32'd1);
        check("part_we",   32'(ofm_we),   32'd0);

        // Completion: beats 2..6 spaced out, then an extra beat that must be ignored
        for (int i = 1; i < 6; i++) begin
            drive_beat(make_beat(8'(8'h10 * i + 8'h03)), 1'b1);
            for (int j = 0; j < 3; j++) tick();
        end
        drive_beat(make_beat(8'hE0), 1'b0);
        wait_drain("drain_layer");
        check("last_we",   32'(ofm_we), 32'd1);
        check("last_addr", ofm_addr,    BASE + 32'd23);
        check("pre_done",  32'(done),   32'd0);
        tick();
        check("done_set",  32'(done),   32'd1);
        check("done_busy", 32'(busy),   32'd0);
        check("done_we",   32'(ofm_we), 32'd0);
        check("done_lerr", 32'(lane_err), 32'd1);
        drive_beat(make_beat(8'h99), 1'b0);
        tick();
        check("done_ovf",  32'(overflow), 32'd0);

        // Restart from DONE clears flags; then backpressure with 8 back-to-back beats
        pulse_start();
        check("rs_lerr", 32'(lane_err), 32'd0);
        check("rs_done", 32'(done),     32'd0);
        check("rs_busy", 32'(busy),     32'd1);
        for (int i = 0; i < 8; i++) begin
            valid  = 16'hFFFF;
            b      = make_beat(8'(8'h20 * i + 8'h01));
            ofm_in = b;
            // beat 4 meets a full FIFO (pop same edge is too late); beats 6,7 meet it full again
            if (i != 4 && i < 6) begin
                for (int w = 0; w < 4; w++) begin
                    exp_q.push_back('{addr: exp_addr, data: exp_word(b, w)});
                    exp_addr = exp_addr + 32'd1;
                end
            end
            tick();
            if (i == 3) check("bp_ready_low",  32'(ofm_ready), 32'd0);
            if (i == 4) check("bp_ready_high", 32'(ofm_ready), 32'd1);
            if (i == 4) check("bp_ovf",        32'(overflow),  32'd1);
        end
        valid = '0;
        wait_drain("drain_bp");
        tick();
        tick();
        check("bp_still_busy", 32'(busy), 32'd1);
        check("bp_not_done",   32'(done), 32'd0);
        check("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Reset between word 1 and word 2 of a beat
        drive_beat(make_beat(8'h70), 1'b1);
        tick();
        tick();
        check("rm_remaining", 32'(exp_q.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rm_we_async", 32'(ofm_we), 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("rm_busy",  32'(busy),      32'd0);
        check("rm_done",  32'(done),      32'd0);
        check("rm_addr",  ofm_addr,       BASE);
        check("rm_ovf",   32'(overflow),  32'd0);
        check("rm_ready", 32'(ofm_ready), 32'd1);
        check("rm_we",    32'(ofm_we),    32'd0);

        // New layer rewrites from base; lane bytes exercise the optional clamp
        pulse_start();
        b = make_beat(8'h00);
        b[31:0] = 32'h01FF7F80;
        drive_beat(b, 1'b1);
        tick();
        check("relu_addr", ofm_addr, BASE);
`ifdef OFM_WB_RELU_EN
        check("relu_w0", ofm_data, 32'h007F0001);
`else
        check("relu_w0", ofm_data, 32'h807FFF01);
`endif
        wait_drain("drain_relu");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
